spike_train_decoder: RTL and testbench

//   Receive side of the neuron spike interface. Takes the pre- and post-synaptic spike lines
//   (spike1/spike2 of the two-neuron STDP core) and reduces them to per-window records.

---
 rtl/spike_dec_pkg.sv | 29 ++
 rtl/spike_edge_counter.sv | 38 +++
 rtl/spike_train_decoder.sv | 180 ++++++++++++++++++
 tb/tb_spike_train_decoder.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_dec_pkg.sv
// Shared types for the spike train decoder: FSM states, the output record layout
// and the "no post spike" latency sentinel.
package spike_dec_pkg;

    typedef enum logic {
        S_IDLE,
        S_COUNT
    } state_t;

    // Record fields are sized for the widest supported build (CNT_W <= 16, WINDOW <= 128);
    // the top slices them down to its own widths.
    localparam int REC_CNT_W = 16;
    localparam int REC_LAT_W = 8;
    localparam int REC_DT_W  = REC_LAT_W + 1;

    typedef struct packed {
        logic [REC_CNT_W-1:0] pre_cnt;
        logic [REC_CNT_W-1:0] post_cnt;
        logic [REC_LAT_W-1:0] lat;
        logic                 overrun;
        logic [REC_DT_W-1:0]  dt;
        logic                 dt_ok;
    } record_t;

    function automatic logic [REC_LAT_W-1:0] lat_sentinel(input int lat_w);
        return REC_LAT_W'((32'd1 << lat_w) - 32'd1);
    endfunction

endpackage

// File: rtl/spike_edge_counter.sv
// Rising-edge detector plus saturating counter for one spike line. o_cnt_next already
// includes the current cycle's edge so a closing window can capture it directly.
module spike_edge_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_line,
    input  logic             i_count_en,
    input  logic             i_clear,
    output logic             o_edge,
    output logic [CNT_W-1:0] o_cnt_next
);
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;

    assign o_edge = i_line & ~r_prev;

    always_comb begin
        o_cnt_next = r_cnt;
        if (i_count_en && o_edge && (r_cnt != '1)) begin
            o_cnt_next = r_cnt + 1'b1;
        end
    end

    // The previous sample tracks the line at all times so a level that was already
    // high before a window starts is not mistaken for a fresh edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_prev <= i_line;
            r_cnt  <= i_clear ? '0 : o_cnt_next;
        end
    end

endmodule

// File: rtl/spike_train_decoder.sv
// Reduces pre/post spike lines to per-window records behind a valid/ready port.
// Define SPIKE_DT_EN to build the first-post minus latest-pre timing field (out_dt).
module spike_train_decoder
    import spike_dec_pkg::*;
#(
    parameter int  WINDOW = 16,
    parameter int  CNT_W  = 8,
    localparam int LAT_W  = $clog2(WINDOW) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             spike_pre,
    input  logic             spike_post,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_pre_cnt,
    output logic [CNT_W-1:0] out_post_cnt,
    output logic [LAT_W-1:0] out_lat,
    output logic             out_overrun,
    output logic [LAT_W:0]   out_dt,
    output logic             out_dt_ok
);
    localparam int IDX_W = LAT_W - 1;

    state_t           r_state, w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic             w_counting, w_close, w_clear, w_can_write;
    logic [1:0]       w_line, w_edge_raw;
    logic [CNT_W-1:0] w_cnt_next [2];
    logic             w_pre_edge, w_post_edge, w_first_post;
    logic             r_lat_found;
    logic [IDX_W-1:0] r_lat;
    logic [LAT_W-1:0] w_lat_rec;
    logic [LAT_W:0]   w_dt_rec;
    logic             w_dt_ok_rec;
    logic             r_valid, r_pending;
    record_t          r_rec, w_rec;
    logic             w_unused_rec;

    assign w_counting  = (r_state == S_COUNT) && enable;
    assign w_close     = w_counting && (r_idx == IDX_W'(WINDOW - 1));
    assign w_clear     = !w_counting || w_close;
    assign w_can_write = !r_valid || out_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (enable)  w_state_next = S_COUNT;
            S_COUNT: if (!enable) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_counting ? r_idx + 1'b1 : '0;
        end
    end

    // Index 0 is the pre line, index 1 the post line.
    assign w_line = {spike_post, spike_pre};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        spike_edge_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .i_line    (w_line[gi]),
            .i_count_en(w_counting),
            .i_clear   (w_clear),
            .o_edge    (w_edge_raw[gi]),
            .o_cnt_next(w_cnt_next[gi])
        );
    end

    assign w_pre_edge   = w_edge_raw[0] & w_counting;
    assign w_post_edge  = w_edge_raw[1] & w_counting;
    assign w_first_post = w_post_edge & ~r_lat_found;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lat_found <= 1'b0;
            r_lat       <= '0;
        end else if (w_clear) begin
            r_lat_found <= 1'b0;
            r_lat       <= '0;
        end else if (w_first_post) begin
            r_lat_found <= 1'b1;
            r_lat       <= r_idx;
        end
    end

    assign w_lat_rec = r_lat_found  ? {1'b0, r_lat} :
                       w_first_post ? {1'b0, r_idx} : LAT_W'(lat_sentinel(LAT_W));

`ifdef SPIKE_DT_EN
    logic             r_pre_seen, r_dt_ok;
    logic [IDX_W-1:0] r_pre_idx;
    logic [LAT_W:0]   r_dt, w_dt_now;
    logic             w_ref_seen;
    logic [IDX_W-1:0] w_ref_idx;

    // A pre edge in the same cycle as the first post edge is the reference (dt = 0).
    assign w_ref_seen = w_pre_edge | r_pre_seen;
    assign w_ref_idx  = w_pre_edge ? r_idx : r_pre_idx;
    assign w_dt_now   = {2'b00, r_idx} - {2'b00, w_ref_idx};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre_seen <= 1'b0;
            r_pre_idx  <= '0;
            r_dt       <= '0;
            r_dt_ok    <= 1'b0;
        end else if (w_clear) begin
            r_pre_seen <= 1'b0;
            r_pre_idx  <= '0;
            r_dt       <= '0;
            r_dt_ok    <= 1'b0;
        end else begin
            if (w_pre_edge) begin
                r_pre_seen <= 1'b1;
                r_pre_idx  <= r_idx;
            end
            if (w_first_post) begin
                r_dt    <= w_ref_seen ? w_dt_now : '0;
                r_dt_ok <= w_ref_seen;
            end
        end
    end

    assign w_dt_rec    = r_lat_found ? r_dt : ((w_first_post && w_ref_seen) ? w_dt_now : '0);
    assign w_dt_ok_rec = r_lat_found ? r_dt_ok : (w_first_post && w_ref_seen);
`else
    assign w_dt_rec    = '0;
    assign w_dt_ok_rec = 1'b0;
`endif

    always_comb begin
        w_rec          = '0;
        w_rec.pre_cnt  = REC_CNT_W'(w_cnt_next[0]);
        w_rec.post_cnt = REC_CNT_W'(w_cnt_next[1]);
        w_rec.lat      = REC_LAT_W'(w_lat_rec);
        w_rec.overrun  = r_pending;
        w_rec.dt       = REC_DT_W'(w_dt_rec);
        w_rec.dt_ok    = w_dt_ok_rec;
    end

    // A closing window that finds the register full and unaccepted is dropped; the
    // next record that does get written reports the loss.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rec     <= '0;
            r_valid   <= 1'b0;
            r_pending <= 1'b0;
        end else if (w_close && w_can_write) begin
            r_rec     <= w_rec;
            r_valid   <= 1'b1;
            r_pending <= 1'b0;
        end else begin
            if (out_ready) r_valid <= 1'b0;
            if (w_close)   r_pending <= 1'b1;
        end
    end

    assign out_valid    = r_valid;
    assign out_pre_cnt  = r_rec.pre_cnt[CNT_W-1:0];
    assign out_post_cnt = r_rec.post_cnt[CNT_W-1:0];
    assign out_lat      = r_rec.lat[LAT_W-1:0];
    assign out_overrun  = r_rec.overrun;
    assign out_dt       = r_rec.dt[LAT_W:0];
    assign out_dt_ok    = r_rec.dt_ok;
    assign w_unused_rec = ^r_rec;

endmodule

// File: tb/tb_spike_train_decoder.sv
// Randomised bench for spike_train_decoder: a window-level reference model checks a
// CNT_W=8 instance and a CNT_W=3 instance (saturation) fed with the same stimulus.
`timescale 1ns/1ps
module tb_spike_train_decoder;
    localparam int WINDOW = 16;
    localparam int CNT_W  = 8;
    localparam int LAT_W  = 5;
    localparam int DT_W   = LAT_W + 1;
    localparam int SCNT_W = 3;

    logic              clk = 1'b0;
    logic              reset, enable, spike_pre, spike_post, out_ready;
    logic              out_valid, out_overrun, out_dt_ok;
    logic [CNT_W-1:0]  out_pre_cnt, out_post_cnt;
    logic [LAT_W-1:0]  out_lat;
    logic [LAT_W:0]    out_dt;
    logic              s_out_valid, s_out_overrun, s_out_dt_ok;
    logic [SCNT_W-1:0] s_out_pre_cnt, s_out_post_cnt;
    logic [LAT_W-1:0]  s_out_lat;
    logic [LAT_W:0]    s_out_dt;

    spike_train_decoder #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .spike_pre(spike_pre), .spike_post(spike_post),
        .out_valid(out_valid), .out_ready(out_ready), .out_pre_cnt(out_pre_cnt),
        .out_post_cnt(out_post_cnt), .out_lat(out_lat), .out_overrun(out_overrun),
        .out_dt(out_dt), .out_dt_ok(out_dt_ok)
    );

    spike_train_decoder #(.WINDOW(WINDOW), .CNT_W(SCNT_W)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .spike_pre(spike_pre), .spike_post(spike_post),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_pre_cnt(s_out_pre_cnt),
        .out_post_cnt(s_out_post_cnt), .out_lat(s_out_lat), .out_overrun(s_out_overrun),
        .out_dt(s_out_dt), .out_dt_ok(s_out_dt_ok)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int pre;
        int post;
        int lat;
        bit ovr;
        int dt;
        bit dt_ok;
    } rec_t;

    // Reference model state: samples of the current window and the output slot.
    bit   m_active, m_last_pre, m_last_post, m_start_pre, m_start_post;
    int   m_idx, n_windows;
    bit   m_win_pre [WINDOW];
    bit   m_win_post[WINDOW];
    bit   e_valid, e_pend;
    rec_t e_rec;

    function automatic rec_t window_record();
        rec_t r;
        int   last_pre;
        bit   pe, po;
        r = '{pre: 0, post: 0, lat: (1 << LAT_W) - 1, ovr: 1'b0, dt: 0, dt_ok: 1'b0};
        last_pre = -1;
        for (int i = 0; i < WINDOW; i++) begin
            pe = m_win_pre[i]  && !((i == 0) ? m_start_pre  : m_win_pre[i-1]);
            po = m_win_post[i] && !((i == 0) ? m_start_post : m_win_post[i-1]);
            if (pe) begin
                r.pre++;
                last_pre = i;
            end
            if (po) begin
                if (r.post == 0) begin
                    r.lat = i;
`ifdef SPIKE_DT_EN
                    if (last_pre >= 0) begin
                        r.dt    = i - last_pre;
                        r.dt_ok = 1'b1;
                    end
`endif
                end
                r.post++;
            end
        end
        return r;
    endfunction

    function automatic logic [36:0] exp_vec();
        logic [28:0] a;
        logic [5:0]  b;
        int          p8, q8, p3, q3;
        p8 = (e_rec.pre  > 255) ? 255 : e_rec.pre;
        q8 = (e_rec.post > 255) ? 255 : e_rec.post;
        p3 = (e_rec.pre  > 7)   ? 7   : e_rec.pre;
        q3 = (e_rec.post > 7)   ? 7   : e_rec.post;
        a = e_valid ? {8'(p8), 8'(q8), LAT_W'(e_rec.lat), e_rec.ovr, DT_W'(e_rec.dt), e_rec.dt_ok} : '0;
        b = e_valid ? {3'(p3), 3'(q3)} : '0;
        return {e_valid, a, e_valid, b};
    endfunction

    function automatic logic [36:0] obs_vec();
        logic [28:0] a;
        logic [5:0]  b;
        a = out_valid ? {out_pre_cnt, out_post_cnt, out_lat, out_overrun, out_dt, out_dt_ok} : '0;
        b = s_out_valid ? {s_out_pre_cnt, s_out_post_cnt} : '0;
        return {out_valid, a, s_out_valid, b};
    endfunction

    task automatic model_clear();
        m_active = 0; m_idx = 0; m_last_pre = 0; m_last_post = 0;
        e_valid = 0; e_pend = 0;
        e_rec = '{pre: 0, post: 0, lat: 0, ovr: 1'b0, dt: 0, dt_ok: 1'b0};
    endtask

    // One clock: drive inputs, advance the reference model by the rules, sample at edge+1.
    task automatic cycle(input bit pre, input bit post, input bit en, input bit rdy);
        bit   close;
        rec_t r;
        spike_pre = pre; spike_post = post; enable = en; out_ready = rdy;
        @(posedge clk);
        close = 0;
        if (m_active && en) begin
            if (m_idx == 0) begin
                m_start_pre  = m_last_pre;
                m_start_post = m_last_post;
            end
            m_win_pre[m_idx]  = pre;
            m_win_post[m_idx] = post;
            if (m_idx == WINDOW - 1) begin
                close = 1;
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end else if (m_active) begin
            m_active = 0;
        end else if (en) begin
            m_active = 1;
            m_idx    = 0;
        end
        m_last_pre  = pre;
        m_last_post = post;
        if (close) begin
            r = window_record();
            n_windows++;
            if (!e_valid || rdy) begin
                r.ovr   = e_pend;
                e_rec   = r;
                e_pend  = 0;
                e_valid = 1;
            end else begin
                e_pend = 1;
            end
            $display("window %0d: pre=%0d post=%0d lat=%0d dt=%0d dt_ok=%0b %s", n_windows,
                     r.pre, r.post, r.lat, r.dt, r.dt_ok, (e_pend ? "dropped" : "written"));
        end else if (rdy) begin
            e_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; enable = 0; spike_pre = 0; spike_post = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_pre_cnt, out_post_cnt, out_lat, out_overrun, out_dt, out_dt_ok,
             s_out_valid, s_out_pre_cnt, s_out_post_cnt, s_out_lat, s_out_overrun, s_out_dt, s_out_dt_ok} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b pre=%h post=%h lat=%h ovr=%b dt=%h ok=%b required all 0",
                     out_valid, out_pre_cnt, out_post_cnt, out_lat, out_overrun, out_dt, out_dt_ok);
        end
        reset = 0;
        model_clear();
    endtask

    task automatic test_no_spikes();
        int n = 0;
        for (int c = 0; c < 40; c++) begin
            cycle(0, 0, 1, 1);
            n++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL no_spikes cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (out_valid) break;
        end
        checks++;
        if (!out_valid || n != 17) begin
            errors++;
            $display("FAIL no_spikes_latency got %0d edges (valid=%b) required 17", n, out_valid);
        end
        checks++;
        if ({out_pre_cnt, out_post_cnt, out_lat, out_dt_ok} !== {8'd0, 8'd0, 5'd31, 1'b0}) begin
            errors++;
            $display("FAIL no_spikes_record got pre=%0d post=%0d lat=%0d ok=%b required 0/0/31/0",
                     out_pre_cnt, out_post_cnt, out_lat, out_dt_ok);
        end
    endtask

    task automatic test_pulses();
        for (int i = 0; i < WINDOW; i++) begin
            cycle(m_idx == 2 || m_idx == 5, m_idx == 7, 1, 1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL pulses i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({out_valid, out_pre_cnt, out_post_cnt, out_lat} !== {1'b1, 8'd2, 8'd1, 5'd7}) begin
            errors++;
            $display("FAIL pulses_record got v=%b pre=%0d post=%0d lat=%0d required 1/2/1/7",
                     out_valid, out_pre_cnt, out_post_cnt, out_lat);
        end
`ifdef SPIKE_DT_EN
        checks++;
        if ({out_dt, out_dt_ok} !== {6'd2, 1'b1}) begin
            errors++;
            $display("FAIL pulses_dt got dt=%0d ok=%b required 2/1", $signed(out_dt), out_dt_ok);
        end
`endif
    endtask

    task automatic test_held_level();
        for (int i = 0; i < WINDOW; i++) begin
            cycle(m_idx >= 3 && m_idx <= 6, m_idx == 0, 1, 1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL held i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({out_valid, out_pre_cnt, out_post_cnt, out_lat, out_dt_ok} !== {1'b1, 8'd1, 8'd1, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL held_record got v=%b pre=%0d post=%0d lat=%0d ok=%b required 1/1/1/0/0",
                     out_valid, out_pre_cnt, out_post_cnt, out_lat, out_dt_ok);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < WINDOW; i++) begin
            cycle(m_idx % 2 == 0, 0, 1, 1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL saturate i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({out_pre_cnt, s_out_pre_cnt} !== {8'd8, 3'd7}) begin
            errors++;
            $display("FAIL saturate_cnt got wide=%0d narrow=%0d required 8/7", out_pre_cnt, s_out_pre_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit rdy;
        for (int w = 1; w <= 5; w++) begin
            for (int i = 0; i < WINDOW; i++) begin
                rdy = !(w <= 3 && !(w == 1 && i == 0));
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 1, rdy);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL backpressure w=%0d i=%0d got=%h exp=%h", w, i, obs_vec(), exp_vec());
                end
            end
            if (w >= 4) begin
                checks++;
                if ({out_valid, out_overrun} !== {1'b1, (w == 4)}) begin
                    errors++;
                    $display("FAIL backpressure_overrun w=%0d got v=%b ovr=%b required 1/%0b",
                             w, out_valid, out_overrun, (w == 4));
                end
            end
        end
    endtask

    task automatic test_abort();
        int nvalid = 0;
        for (int i = 0; i < 9; i++) begin
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 1, 1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL abort_pre i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 20; i++) begin
            cycle($urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, 0, 1);
            if (out_valid) nvalid++;
        end
        checks++;
        if (nvalid != 0) begin
            errors++;
            $display("FAIL abort_no_record got %0d valid cycles required 0", nvalid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        int n = 0;
        for (int c = 0; c < 60 && !hit; c++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_setup cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            hit = e_valid && m_active && (m_idx == 9);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_reach got valid=%b idx=%0d required valid=1 idx=9", out_valid, m_idx);
        end
        reset = 1;
        #1;
        checks++;
        if ({out_valid, out_pre_cnt, out_post_cnt, out_lat, out_overrun, out_dt, out_dt_ok} !== '0) begin
            errors++;
            $display("FAIL reset_mid_clear got valid=%b pre=%0d post=%0d lat=%0d ovr=%b required all 0",
                     out_valid, out_pre_cnt, out_post_cnt, out_lat, out_overrun);
        end
        enable = 0;
        @(posedge clk);
        #1;
        reset = 0;
        model_clear();
        for (int c = 0; c < 40; c++) begin
            cycle(0, 0, 1, 1);
            n++;
            if (out_valid) break;
        end
        checks++;
        if (!out_valid || n != 17) begin
            errors++;
            $display("FAIL reset_mid_restart got %0d edges (valid=%b) required 17", n, out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_windows = 0;
        model_clear();
        test_reset();
        test_no_spikes();
        test_pulses();
        test_held_level();
        test_saturate();
        test_backpressure();
        test_abort();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
